// File: rtl/sram_pingpong_interface_if.sv
// Datapath-side bus of the ping-pong SRAM controller: read/write addresses, data and bank select.
// master = compute datapath, slave = sram_pingpong_interface.
interface sram_pingpong_interface_if #(
  parameter int ADDR_W = 8,
  parameter int HALF_W = 64
);
  logic [ADDR_W-1:0]   raddress1, raddress2, waddress1, waddress2;
  logic [2*HALF_W-1:0] rdata1, rdata2, wdata1, wdata2;
  logic                global_write_enable;
  logic                sram_read_register;

  modport master (
    output raddress1, raddress2, waddress1, waddress2, wdata1, wdata2,
    output global_write_enable, sram_read_register,
    input  rdata1, rdata2
  );

  modport slave (
    input  raddress1, raddress2, waddress1, waddress2, wdata1, wdata2,
    input  global_write_enable, sram_read_register,
    output rdata1, rdata2
  );
endinterface

// File: rtl/sram_pingpong_interface.sv
// Ping-pong controller over two dual-port SRAM banks (each bank = two 64-bit macros), one read, one written per cycle.
// Optional macro RDATA_OUT_REG_EN registers rdata once more, giving read latency 2.
module sram_pingpong_interface #(
  parameter int ADDR_W = 8,
  parameter int HALF_W = 64
) (
  input  logic clk,
  input  logic rst,
  sram_pingpong_interface_if.slave bus,
  output logic SRAM0_BIST0, SRAM0_AWT0, SRAM0_CEBA0, SRAM0_CEBB0, SRAM0_WEBA0, SRAM0_WEBB0,
  output logic [ADDR_W-1:0] SRAM0_AA0, SRAM0_AB0,
  output logic [HALF_W-1:0] SRAM0_DA0, SRAM0_DB0, SRAM0_BWEBA0, SRAM0_BWEBB0,
  input  logic [HALF_W-1:0] SRAM0_QA0, SRAM0_QB0,
  output logic SRAM0_BIST1, SRAM0_AWT1, SRAM0_CEBA1, SRAM0_CEBB1, SRAM0_WEBA1, SRAM0_WEBB1,
  output logic [ADDR_W-1:0] SRAM0_AA1, SRAM0_AB1,
  output logic [HALF_W-1:0] SRAM0_DA1, SRAM0_DB1, SRAM0_BWEBA1, SRAM0_BWEBB1,
  input  logic [HALF_W-1:0] SRAM0_QA1, SRAM0_QB1,
  output logic SRAM1_BIST0, SRAM1_AWT0, SRAM1_CEBA0, SRAM1_CEBB0, SRAM1_WEBA0, SRAM1_WEBB0,
  output logic [ADDR_W-1:0] SRAM1_AA0, SRAM1_AB0,
  output logic [HALF_W-1:0] SRAM1_DA0, SRAM1_DB0, SRAM1_BWEBA0, SRAM1_BWEBB0,
  input  logic [HALF_W-1:0] SRAM1_QA0, SRAM1_QB0,
  output logic SRAM1_BIST1, SRAM1_AWT1, SRAM1_CEBA1, SRAM1_CEBB1, SRAM1_WEBA1, SRAM1_WEBB1,
  output logic [ADDR_W-1:0] SRAM1_AA1, SRAM1_AB1,
  output logic [HALF_W-1:0] SRAM1_DA1, SRAM1_DB1, SRAM1_BWEBA1, SRAM1_BWEBB1,
  input  logic [HALF_W-1:0] SRAM1_QA1, SRAM1_QB1
);
  localparam int DATA_W = 2 * HALF_W;

  // Per-bank control, indexed by bank; both halves of a bank share it.
  logic [1:0]             ceba, cebb, weba, webb;
  logic [1:0][ADDR_W-1:0] aa, ab;
  logic [1:0][DATA_W-1:0] da, db;
  logic                   rbank, wbank, wr_en, collide;

  always_comb begin
    ceba    = '1;
    cebb    = '1;
    weba    = '1;
    webb    = '1;
    aa      = '0;
    ab      = '0;
    da      = '0;
    db      = '0;
    rbank   = bus.sram_read_register;
    wbank   = ~bus.sram_read_register;
    wr_en   = bus.global_write_enable && !rst;
    collide = wr_en && (bus.waddress1 == bus.waddress2);
    if (!rst) begin
      ceba[rbank] = 1'b0;
      cebb[rbank] = 1'b0;
      aa[rbank]   = bus.raddress1;
      ab[rbank]   = bus.raddress2;
    end
    // Same-address writes: port B is dropped so write 1 lands.
    if (wr_en) begin
      ceba[wbank] = 1'b0;
      weba[wbank] = 1'b0;
      cebb[wbank] = collide;
      webb[wbank] = collide;
      aa[wbank]   = bus.waddress1;
      ab[wbank]   = bus.waddress2;
      da[wbank]   = bus.wdata1;
      db[wbank]   = bus.wdata2;
    end
  end

  assign {SRAM0_BIST0, SRAM0_AWT0, SRAM0_BIST1, SRAM0_AWT1} = 4'b0000;
  assign {SRAM1_BIST0, SRAM1_AWT0, SRAM1_BIST1, SRAM1_AWT1} = 4'b0000;
  assign {SRAM0_BWEBA0, SRAM0_BWEBB0, SRAM0_BWEBA1, SRAM0_BWEBB1} = '0;
  assign {SRAM1_BWEBA0, SRAM1_BWEBB0, SRAM1_BWEBA1, SRAM1_BWEBB1} = '0;

  assign {SRAM0_CEBA0, SRAM0_CEBB0, SRAM0_WEBA0, SRAM0_WEBB0} = {ceba[0], cebb[0], weba[0], webb[0]};
  assign {SRAM0_CEBA1, SRAM0_CEBB1, SRAM0_WEBA1, SRAM0_WEBB1} = {ceba[0], cebb[0], weba[0], webb[0]};
  assign {SRAM1_CEBA0, SRAM1_CEBB0, SRAM1_WEBA0, SRAM1_WEBB0} = {ceba[1], cebb[1], weba[1], webb[1]};
  assign {SRAM1_CEBA1, SRAM1_CEBB1, SRAM1_WEBA1, SRAM1_WEBB1} = {ceba[1], cebb[1], weba[1], webb[1]};

  assign {SRAM0_AA0, SRAM0_AB0, SRAM0_AA1, SRAM0_AB1} = {aa[0], ab[0], aa[0], ab[0]};
  assign {SRAM1_AA0, SRAM1_AB0, SRAM1_AA1, SRAM1_AB1} = {aa[1], ab[1], aa[1], ab[1]};

  assign {SRAM0_DA0, SRAM0_DB0} = {da[0][HALF_W-1:0], db[0][HALF_W-1:0]};
  assign {SRAM0_DA1, SRAM0_DB1} = {da[0][DATA_W-1:HALF_W], db[0][DATA_W-1:HALF_W]};
  assign {SRAM1_DA0, SRAM1_DB0} = {da[1][HALF_W-1:0], db[1][HALF_W-1:0]};
  assign {SRAM1_DA1, SRAM1_DB1} = {da[1][DATA_W-1:HALF_W], db[1][DATA_W-1:HALF_W]};

  // ---- stage p0 -> p1: remember which bank was read at the edge the macros captured ----
  logic rd_sel_q, rd_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sel_q <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_sel_q <= bus.sram_read_register;
      rd_vld_q <= 1'b1;
    end
  end

  logic [DATA_W-1:0] q1, q2;

  always_comb begin
    q1 = '0;
    q2 = '0;
    if (rd_vld_q) begin
      q1 = rd_sel_q ? {SRAM1_QA1, SRAM1_QA0} : {SRAM0_QA1, SRAM0_QA0};
      q2 = rd_sel_q ? {SRAM1_QB1, SRAM1_QB0} : {SRAM0_QB1, SRAM0_QB0};
    end
  end

`ifdef RDATA_OUT_REG_EN
  // ---- stage p1 -> p2: output register; gated q makes this the second valid stage ----
  logic [DATA_W-1:0] rdata1_p2, rdata2_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata1_p2 <= '0;
      rdata2_p2 <= '0;
    end else begin
      rdata1_p2 <= q1;
      rdata2_p2 <= q2;
    end
  end

  assign bus.rdata1 = rdata1_p2;
  assign bus.rdata2 = rdata2_p2;
`else
  assign bus.rdata1 = q1;
  assign bus.rdata2 = q2;
`endif
endmodule

// File: tb/tb_sram_pingpong_interface.sv
// Bench for sram_pingpong_interface: behavioural SRAM macros, directed vector table, hand corner cases,
// and randomized traffic checked against a bank/word-level memory model.
module tb_sram_pingpong_interface;
`ifdef RDATA_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [127:0] VA = 128'hAAAA_AAAA_BBBB_BBBB_CCCC_CCCC_DDDD_DDDD;
  localparam logic [127:0] VB = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] VC = 128'hDEAD_BEEF_DEAD_BEEF_0000_0000_1111_1111;
  localparam logic [127:0] VD = 128'hCAFE_BABE_CAFE_BABE_9999_9999_8888_8888;
  localparam logic [127:0] HM = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_pingpong_interface_if #(.ADDR_W(8), .HALF_W(64)) bus ();

  wire [1:0][1:0]       bist, awt, ceba, cebb, weba, webb;
  wire [1:0][1:0][7:0]  aa, ab;
  wire [1:0][1:0][63:0] da, db, bweba, bwebb;
  logic [63:0] qa [2][2];
  logic [63:0] qb [2][2];
  logic [63:0] mem [2][2][256];

  sram_pingpong_interface #(.ADDR_W(8), .HALF_W(64)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .SRAM0_BIST0(bist[0][0]), .SRAM0_AWT0(awt[0][0]), .SRAM0_CEBA0(ceba[0][0]), .SRAM0_CEBB0(cebb[0][0]),
    .SRAM0_WEBA0(weba[0][0]), .SRAM0_WEBB0(webb[0][0]), .SRAM0_AA0(aa[0][0]), .SRAM0_AB0(ab[0][0]),
    .SRAM0_DA0(da[0][0]), .SRAM0_DB0(db[0][0]), .SRAM0_BWEBA0(bweba[0][0]), .SRAM0_BWEBB0(bwebb[0][0]),
    .SRAM0_QA0(qa[0][0]), .SRAM0_QB0(qb[0][0]),
    .SRAM0_BIST1(bist[0][1]), .SRAM0_AWT1(awt[0][1]), .SRAM0_CEBA1(ceba[0][1]), .SRAM0_CEBB1(cebb[0][1]),
    .SRAM0_WEBA1(weba[0][1]), .SRAM0_WEBB1(webb[0][1]), .SRAM0_AA1(aa[0][1]), .SRAM0_AB1(ab[0][1]),
    .SRAM0_DA1(da[0][1]), .SRAM0_DB1(db[0][1]), .SRAM0_BWEBA1(bweba[0][1]), .SRAM0_BWEBB1(bwebb[0][1]),
    .SRAM0_QA1(qa[0][1]), .SRAM0_QB1(qb[0][1]),
    .SRAM1_BIST0(bist[1][0]), .SRAM1_AWT0(awt[1][0]), .SRAM1_CEBA0(ceba[1][0]), .SRAM1_CEBB0(cebb[1][0]),
    .SRAM1_WEBA0(weba[1][0]), .SRAM1_WEBB0(webb[1][0]), .SRAM1_AA0(aa[1][0]), .SRAM1_AB0(ab[1][0]),
    .SRAM1_DA0(da[1][0]), .SRAM1_DB0(db[1][0]), .SRAM1_BWEBA0(bweba[1][0]), .SRAM1_BWEBB0(bwebb[1][0]),
    .SRAM1_QA0(qa[1][0]), .SRAM1_QB0(qb[1][0]),
    .SRAM1_BIST1(bist[1][1]), .SRAM1_AWT1(awt[1][1]), .SRAM1_CEBA1(ceba[1][1]), .SRAM1_CEBB1(cebb[1][1]),
    .SRAM1_WEBA1(weba[1][1]), .SRAM1_WEBB1(webb[1][1]), .SRAM1_AA1(aa[1][1]), .SRAM1_AB1(ab[1][1]),
    .SRAM1_DA1(da[1][1]), .SRAM1_DB1(db[1][1]), .SRAM1_BWEBA1(bweba[1][1]), .SRAM1_BWEBB1(bwebb[1][1]),
    .SRAM1_QA1(qa[1][1]), .SRAM1_QB1(qb[1][1])
  );

  // Dual-port macro models: synchronous read, write when CEB and WEB are both low.
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      for (int h = 0; h < 2; h++) begin
        if (!ceba[b][h]) begin
          if (!weba[b][h]) mem[b][h][aa[b][h]] <= da[b][h];
          else qa[b][h] <= mem[b][h][aa[b][h]];
        end
        if (!cebb[b][h]) begin
          if (!webb[b][h]) mem[b][h][ab[b][h]] <= db[b][h];
          else qb[b][h] <= mem[b][h][ab[b][h]];
        end
      end
    end
  end

  typedef struct {
    bit sel, we;
    logic [7:0] ra1, ra2, wa1, wa2;
    logic [127:0] wd1, wd2;
    bit chk;
    logic [127:0] e1, e2;
  } vec_t;

  typedef struct {
    bit chk;
    int tag;
    logic [127:0] e1, e2;
  } exp_t;

  logic [127:0] ref_mem [2][256];
  exp_t pend[$];
  vec_t tab[7];
  vec_t v;
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input vec_t x);
    bus.sram_read_register  = x.sel;
    bus.global_write_enable = x.we;
    bus.raddress1 = x.ra1;
    bus.raddress2 = x.ra2;
    bus.waddress1 = x.wa1;
    bus.waddress2 = x.wa2;
    bus.wdata1    = x.wd1;
    bus.wdata2    = x.wd2;
  endtask

  // One cycle: issue, commit writes to the word-level model, check whatever read has now matured.
  task automatic apply(input vec_t x, input int tag);
    exp_t p;
    drive(x);
    @(posedge clk);
    #1;
    if (x.we) begin
      ref_mem[!x.sel][x.wa1] = x.wd1;
      if (x.wa2 != x.wa1) ref_mem[!x.sel][x.wa2] = x.wd2;
    end
    pend.push_back('{x.chk, tag, x.e1, x.e2});
    if (pend.size() >= LAT) begin
      p = pend.pop_front();
      if (p.chk) begin
        check($sformatf("rdata1_t%0d", p.tag), bus.rdata1, p.e1);
        check($sformatf("rdata2_t%0d", p.tag), bus.rdata2, p.e2);
      end
    end
  endtask

  task automatic flush();
    vec_t idle;
    idle = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, '0, '0, 1'b0, '0, '0};
    for (int i = 0; i < LAT - 1; i++) apply(idle, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int b = 0; b < 2; b++) begin
      for (int h = 0; h < 2; h++) begin
        qa[b][h] = '0;
        qb[b][h] = '0;
        for (int a = 0; a < 256; a++) mem[b][h][a] = '0;
      end
      for (int a = 0; a < 256; a++) ref_mem[b][a] = '0;
    end

    // Reset with busy-looking inputs: macros must stay idle, rdata zero.
    drive('{1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, VA, VB, 1'b0, '0, '0});
    #2;
    check("rst_ceb_web", 128'({ceba, cebb, weba, webb}), 128'hFFFF);
    check("rst_addr", 128'({aa, ab}), '0);
    check("rst_data", 128'(|{da, db}), '0);
    check("tie_offs", 128'({bist, awt, |{bweba, bwebb}}), '0);
    check("rst_rdata1", bus.rdata1, '0);
    check("rst_rdata2", bus.rdata2, '0);
    @(posedge clk);
    #1;
    check("rst_rdata_edge", bus.rdata1 | bus.rdata2, '0);
    rst = 1'b0;
    #1;
    check("rel_rdata", bus.rdata1 | bus.rdata2, '0);
    check("rel_read_bank_ceb", 128'({ceba[1], cebb[1], weba[1], webb[1]}), 128'h0F);

    // Directed ping-pong traffic: {sel, we, ra1, ra2, wa1, wa2, wd1, wd2, chk, e1, e2}
    tab[0] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h30, 8'h40, '0, '0, 1'b0, '0, '0};
    tab[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h1A, 8'h1B, VA, VB, 1'b0, '0, '0};
    tab[2] = '{1'b1, 1'b1, 8'h1A, 8'h1B, 8'h2A, 8'h2B, VC, VD, 1'b1, VA, VB};
    tab[3] = '{1'b0, 1'b0, 8'h2A, 8'h2B, 8'h30, 8'h31, '1, '1, 1'b1, VC, VD};
    tab[4] = '{1'b1, 1'b1, 8'h30, 8'h30, 8'h40, 8'h40, 128'h1, 128'h2, 1'b1, '0, '0};
    tab[5] = '{1'b0, 1'b0, 8'h40, 8'h40, 8'h00, 8'h00, '0, '0, 1'b1, 128'h1, 128'h1};
    tab[6] = '{1'b1, 1'b0, 8'h1A, 8'h1A, 8'h00, 8'h00, '0, '0, 1'b1, VA, VA};
    for (int i = 0; i < 7; i++) apply(tab[i], i);
    flush();

    // Half mapping on the write bank, and read bank port state in the same cycle.
    v = '{1'b0, 1'b1, 8'h1A, 8'h1B, 8'h05, 8'h06, HM, ~HM, 1'b0, '0, '0};
    drive(v);
    #1;
    check("half1_da", 128'(da[1][1]), 128'h0123_4567_89AB_CDEF);
    check("half0_da", 128'(da[1][0]), 128'hFEDC_BA98_7654_3210);
    check("half_addr", 128'({aa[1][1], aa[1][0], ab[1][1], ab[1][0]}), 128'h0505_0606);
    check("wbank_ctl", 128'({ceba[1], weba[1], cebb[1], webb[1]}), 128'h00);
    check("rbank_ctl", 128'({ceba[0], weba[0], cebb[0], webb[0]}), 128'h33);
    apply(v, 100);
    apply('{1'b1, 1'b0, 8'h05, 8'h06, 8'h00, 8'h00, '0, '0, 1'b1, HM, ~HM}, 101);
    flush();

    // Collision and write gating as seen on the macro pins.
    drive('{1'b1, 1'b1, 8'h00, 8'h00, 8'h40, 8'h40, 128'h1, 128'h2, 1'b0, '0, '0});
    #1;
    check("coll_port_b", 128'({cebb[0], webb[0]}), 128'hF);
    check("coll_port_a", 128'({ceba[0], weba[0]}), 128'h0);
    bus.global_write_enable = 1'b0;
    #1;
    check("gate_ctl", 128'({ceba[0], weba[0], cebb[0], webb[0]}), 128'hFF);
    check("gate_addr_data", 128'({aa[0], ab[0], |da[0], |db[0]}), '0);

    // Randomized traffic in 0x80..0x8F, expectations from the word-level model.
    for (int i = 0; i < 300; i++) begin
      v.sel = 1'($urandom_range(0, 1));
      v.we  = ($urandom_range(0, 3) != 0);
      v.ra1 = 8'h80 + 8'($urandom_range(0, 15));
      v.ra2 = 8'h80 + 8'($urandom_range(0, 15));
      v.wa1 = 8'h80 + 8'($urandom_range(0, 15));
      v.wa2 = 8'h80 + 8'($urandom_range(0, 15));
      v.wd1 = {$urandom(), $urandom(), $urandom(), $urandom()};
      v.wd2 = {$urandom(), $urandom(), $urandom(), $urandom()};
      v.chk = 1'b1;
      v.e1  = ref_mem[v.sel][v.ra1];
      v.e2  = ref_mem[v.sel][v.ra2];
      apply(v, 1000 + i);
    end
    flush();
    pend.delete();

    // Reset in mid-cycle with a write pending: abandoned, contents kept.
    drive('{1'b0, 1'b1, 8'h05, 8'h06, 8'h05, 8'h06, VA, VB, 1'b0, '0, '0});
    #3;
    rst = 1'b1;
    #1;
    check("midrst_ceb_web", 128'({ceba, cebb, weba, webb}), 128'hFFFF);
    check("midrst_rdata", bus.rdata1 | bus.rdata2, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply('{1'b1, 1'b0, 8'h05, 8'h06, 8'h00, 8'h00, '0, '0, 1'b1, HM, ~HM}, 200);
    flush();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
